led_scan_mux: RTL and testbench
===============================

Name: led_scan_mux

Overview:
- Parameterised time-multiplexed seven-segment / LED digit driver. Successor to the fixed 8-digit, one-digit-per-clock scanner.
- Adds:
  - configurable digit count and segment width
  - refresh prescaler
  - anti-ghosting dead time
  - PWM brightness
  - per-digit blank and blink
  - frame-coherent input buffering
  - end-of-frame strobe
- Sits between the calculator display formatter and the board's digit-select and segment pins.

Parameters:
- N_DIGITS, 8, number of digits scanned (2..16).
- SEG_W, 8, segment bits per digit (7 segments + dp).
- PRESCALE, 1024, clocks per digit slot. Must satisfy PRESCALE > BLANK_CYC + 1.
- BLANK_CYC, 16, dead-time clocks at the start of each slot, during which all digits are off.
- DIM_W, 4, brightness control width.
- BLINK_FRAMES, 64, frames per blink half-period (≥1).
- SEG_OFF, all ones (SEG_W bits), segment value driven when a digit is dark.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset. rst=0 resets the block.
- en, in, 1, scan enable.
- digits_in, in, N_DIGITS*SEG_W, digit k (0 = rightmost) at [k*SEG_W +: SEG_W].
- blank_mask, in, N_DIGITS, bit k=1 forces digit k dark.
- blink_mask, in, N_DIGITS, bit k=1 makes digit k blink.
- brightness, in, DIM_W, 0 = dimmest, all ones = full on-time.
- LEDSEL, out, N_DIGITS, active-low digit select. Bit k selects digit k.
- LEDOUT, out, SEG_W, segment pattern for the selected digit.
- frame_done, out, 1, one-clock pulse after the last slot of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - LEDSEL = all ones, LEDOUT = SEG_OFF, frame_done = 0.
  - slot = 0, cyc = 0, frame counter = 0.
  - blink phase = visible (0).
  - frame buffer = SEG_OFF for every digit.
- Counters, updated when en=1:
  - cyc counts 0..PRESCALE-1.
  - At cyc = PRESCALE-1, cyc wraps to 0 and slot advances 0..N_DIGITS-1, wrapping to 0.
- en=0:
  - Next edge forces slot=0 and cyc=0.
  - Outputs are dark (LEDSEL all ones, LEDOUT = SEG_OFF) and frame_done = 0.
  - Frame counter and blink phase hold.
- Frame buffer:
  - Captures digits_in, blank_mask and blink_mask on every edge whose next state is (slot=0, cyc=0). This covers frame wrap and every en=0 cycle.
  - Mid-frame input changes are not displayed until the next frame. No tearing.
- Brightness:
  - Sampled into bright_q on every edge where the next cyc is 0.
  - on_len = ((PRESCALE-BLANK_CYC) * (bright_q+1)) >> DIM_W, computed with no truncation before the shift.
  - on_len is at least 1 whenever PRESCALE-BLANK_CYC ≥ 2^DIM_W. Otherwise bright 0 may give 0 (digit fully dark), which is legal.
- Digit k = slot is lit when all of the following hold:
  - en = 1
  - BLANK_CYC ≤ cyc < BLANK_CYC + on_len
  - blank bit k = 0 in the buffer
  - NOT (blink bit k = 1 AND blink phase = 1)
- Lit digit drive:
  - LEDSEL has only bit k low.
  - LEDOUT = buffered digit k.
- Dark drive: LEDSEL all ones, LEDOUT = SEG_OFF.
- Output timing:
  - LEDSEL, LEDOUT and frame_done are registered.
  - Each reflects the counter state of the previous clock (1-cycle latency).
  - Never more than one LEDSEL bit is low.
  - Any digit-to-digit change passes through at least BLANK_CYC dark clocks.
- frame_done:
  - Asserted for one clock, one cycle after the counter state (slot=N_DIGITS-1, cyc=PRESCALE-1) with en=1.
  - On the same edge as that state, the frame counter increments.
  - When the frame counter reaches BLINK_FRAMES-1, it wraps to 0 and blink phase toggles.
- Simultaneous events: frame wrap, buffer capture, brightness sampling and blink toggle all occur on the same edge with no priority conflict.
- Reset mid-frame: outputs dark immediately (asynchronously). Scanning restarts at slot 0 on the first enabled edge after release.

Test Plan:
- Parameter set for every scenario: N_DIGITS=4, SEG_W=8, PRESCALE=8, BLANK_CYC=2, DIM_W=2, BLINK_FRAMES=2. All scenarios start from reset.
- Basic scan:
  - Stimulus: digits_in = 32'h44332211, brightness=3, en=1, masks=0.
  - Response per 8-clock slot: 2 dark clocks, then 6 clocks of LEDSEL=4'b1110 with LEDOUT=8'h11.
  - Then 1101/8'h22, 1011/8'h33, 0111/8'h44.
  - frame_done pulses once every 32 clocks.
- Brightness:
  - brightness=0 → on_len=1: exactly 1 lit clock per slot.
  - brightness=1 → on_len=3: 3 lit clocks per slot.
  - A change applied mid-slot takes effect at the next slot start.
- Frame coherence: change digits_in to 32'hAAAAAAAA during slot 1 → slots 1-3 still show 22/33/44; the next frame shows AA on all digits.
- Blank and blink:
  - blank_mask=4'b0100 → digit 2 is never lit.
  - blink_mask=4'b0001 → digit 0 is lit in frames 0-1, dark in frames 2-3, and repeats.
- en and reset:
  - en=0 for 5 clocks mid-slot 2 → dark outputs and no frame_done. After en=1, scanning resumes at slot 0 showing the latest digits_in.
  - rst=0 asserted mid-lit-cycle → LEDSEL=4'b1111 and LEDOUT=8'hFF before the next clk edge.

Source files
------------

// File: rtl/led_scan_mux.sv
// Time-multiplexed digit scanner with dead time, PWM dimming, blank/blink and frame-coherent buffering.
// Outputs registered, 1-cycle latency from counter state; free-running, no backpressure.
module led_scan_mux #(
    parameter int              N_DIGITS     = 8,
    parameter int              SEG_W        = 8,
    parameter int              PRESCALE     = 1024,
    parameter int              BLANK_CYC    = 16,
    parameter int              DIM_W        = 4,
    parameter int              BLINK_FRAMES = 64,
    parameter logic [SEG_W-1:0] SEG_OFF     = '1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_DIGITS*SEG_W-1:0]    digits_in,
    input  logic [N_DIGITS-1:0]          blank_mask,
    input  logic [N_DIGITS-1:0]          blink_mask,
    input  logic [DIM_W-1:0]             brightness,
    output logic [N_DIGITS-1:0]          LEDSEL,
    output logic [SEG_W-1:0]             LEDOUT,
    output logic                         frame_done
);

    localparam int          CYC_W   = $clog2(PRESCALE);
    localparam int          SLOT_W  = $clog2(N_DIGITS);
    localparam int          FR_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [31:0] ACT_LEN = 32'(PRESCALE - BLANK_CYC);

    logic [CYC_W-1:0]                   cyc_q, cyc_d;
    logic [SLOT_W-1:0]                  slot_q, slot_d;
    logic [FR_W-1:0]                    frame_q;
    logic                               blink_ph_q;
    logic [DIM_W-1:0]                   bright_q;
    logic [N_DIGITS-1:0][SEG_W-1:0]     buf_dig_q;
    logic [N_DIGITS-1:0]                buf_blank_q;
    logic [N_DIGITS-1:0]                buf_blink_q;
    logic [N_DIGITS-1:0]                ledsel_q, ledsel_d;
    logic [SEG_W-1:0]                   ledout_q, ledout_d;
    logic                               frame_done_q;

    logic        cyc_wrap;
    logic        frame_end;
    logic        capture;
    logic [31:0] on_len;
    logic [31:0] cyc_ext;
    logic        in_window;
    logic        lit;

    assign cyc_wrap  = (cyc_q == CYC_W'(PRESCALE - 1));
    assign frame_end = en && cyc_wrap && (slot_q == SLOT_W'(N_DIGITS - 1));

    always_comb begin
        cyc_d  = '0;
        slot_d = '0;
        if (en) begin
            cyc_d  = cyc_wrap ? '0 : cyc_q + CYC_W'(1);
            slot_d = slot_q;
            if (cyc_wrap) begin
                slot_d = (slot_q == SLOT_W'(N_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
            end
        end
    end

    // Start of a frame (including every disabled cycle) latches the whole display image.
    assign capture = (cyc_d == '0) && (slot_d == '0);

    // Full-width product before the shift so low brightness codes are not rounded away early.
    assign on_len    = (ACT_LEN * (32'(bright_q) + 32'd1)) >> DIM_W;
    assign cyc_ext   = 32'(cyc_q);
    assign in_window = (cyc_ext >= 32'(BLANK_CYC)) && (cyc_ext < 32'(BLANK_CYC) + on_len);
    assign lit       = en && in_window && !buf_blank_q[slot_q]
                       && !(buf_blink_q[slot_q] && blink_ph_q);

    always_comb begin
        ledsel_d = '1;
        ledout_d = SEG_OFF;
        if (lit) begin
            ledsel_d[slot_q] = 1'b0;
            ledout_d         = buf_dig_q[slot_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q        <= '0;
            slot_q       <= '0;
            frame_q      <= '0;
            blink_ph_q   <= 1'b0;
            bright_q     <= '0;
            buf_dig_q    <= {N_DIGITS{SEG_OFF}};
            buf_blank_q  <= '0;
            buf_blink_q  <= '0;
            ledsel_q     <= '1;
            ledout_q     <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            slot_q <= slot_d;
            if (capture) begin
                buf_dig_q   <= digits_in;
                buf_blank_q <= blank_mask;
                buf_blink_q <= blink_mask;
            end
            if (cyc_d == '0) begin
                bright_q <= brightness;
            end
            if (frame_end) begin
                if (frame_q == FR_W'(BLINK_FRAMES - 1)) begin
                    frame_q    <= '0;
                    blink_ph_q <= ~blink_ph_q;
                end else begin
                    frame_q <= frame_q + FR_W'(1);
                end
            end
            ledsel_q     <= ledsel_d;
            ledout_q     <= ledout_d;
            frame_done_q <= frame_end;
        end
    end

    assign LEDSEL     = ledsel_q;
    assign LEDOUT     = ledout_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench for led_scan_mux: a frame-position reference model predicts each output cycle.
module tb_led_scan_mux;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int P  = 8;
    localparam int B  = 2;
    localparam int DW = 2;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [31:0]   digits_in = '0;
    logic [3:0]    blank_mask = '0;
    logic [3:0]    blink_mask = '0;
    logic [1:0]    brightness = '0;
    logic [3:0]    LEDSEL;
    logic [7:0]    LEDOUT;
    logic          frame_done;

    int errors = 0;
    int checks = 0;
    int fd_seen = 0;

    always #5 clk = ~clk;

    led_scan_mux #(
        .N_DIGITS(N), .SEG_W(SW), .PRESCALE(P), .BLANK_CYC(B),
        .DIM_W(DW), .BLINK_FRAMES(BF), .SEG_OFF(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .brightness(brightness),
        .LEDSEL(LEDSEL), .LEDOUT(LEDOUT), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] out;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    // Reference: position within the frame, completed frames, and the snapshot taken at frame start.
    int         m_pos = 0;
    int         m_frames = 0;
    int         m_bright = 0;
    logic [7:0] m_dig [N];
    logic [3:0] m_blank = '0;
    logic [3:0] m_blink = '0;

    always @(posedge clk) begin : model
        int   slot, cyc, on;
        bit   lit, phase;
        logic [3:0] onehot;
        exp_t e;
        if (!rst) begin
            m_pos = 0; m_frames = 0; m_bright = 0;
            m_blank = '0; m_blink = '0;
            for (int k = 0; k < N; k++) m_dig[k] = 8'hFF;
        end else begin
            slot   = m_pos / P;
            cyc    = m_pos % P;
            on     = ((P - B) * (m_bright + 1)) / (1 << DW);
            phase  = ((m_frames / BF) % 2) == 1;
            lit    = en && (cyc >= B) && (cyc < B + on) && !m_blank[slot]
                     && !(m_blink[slot] && phase);
            onehot = 4'(1 << slot);
            e.sel  = lit ? ~onehot : 4'hF;
            e.out  = lit ? m_dig[slot] : 8'hFF;
            e.fd   = en && (m_pos == N * P - 1);
            sb.push_back(e);
            if (en) begin
                if (m_pos == N * P - 1) m_frames++;
                m_pos = (m_pos + 1) % (N * P);
            end else begin
                m_pos = 0;
            end
            if (m_pos % P == 0) m_bright = int'(brightness);
            if (m_pos == 0) begin
                for (int k = 0; k < N; k++) m_dig[k] = digits_in[k*8 +: 8];
                m_blank = blank_mask;
                m_blink = blink_mask;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (LEDSEL !== e.sel || LEDOUT !== e.out || frame_done !== e.fd) begin
                errors++;
                $display("FAIL scan t=%0t got LEDSEL=%b LEDOUT=%h fd=%b, want LEDSEL=%b LEDOUT=%h fd=%b",
                         $time, LEDSEL, LEDOUT, frame_done, e.sel, e.out, e.fd);
            end
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) digits_in = $urandom;
            if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  brightness = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 23) != 0);
            tick(1);
        end
    endtask

    initial begin : driver
        int fd0;
        int found;
        tick(2);
        chk("reset_ledsel", 32'(LEDSEL), 32'hF);
        chk("reset_ledout", 32'(LEDOUT), 32'hFF);
        chk("reset_frame_done", 32'(frame_done), 32'h0);

        // Basic scan: a disabled lead-in loads the buffer before scanning starts.
        digits_in = 32'h44332211; brightness = 2'd3; rst = 1'b1; en = 1'b0;
        tick(3);
        en = 1'b1;
        tick(8);
        fd0 = fd_seen;
        tick(64);
        chk("frame_done_per_64", 32'(fd_seen - fd0), 32'd2);

        brightness = 2'd0; tick(40);
        brightness = 2'd1; tick(45);
        brightness = 2'd3; tick(13);
        digits_in = 32'hAAAAAAAA; tick(70);

        blank_mask = 4'b0100; blink_mask = 4'b0001; tick(160);
        blank_mask = 4'b0000;

        tick(19);
        en = 1'b0; digits_in = 32'h5A6B7C8D; tick(5);
        en = 1'b1; tick(40);

        rand_phase(800);

        blank_mask = '0; blink_mask = '0; brightness = 2'd3; en = 1'b1;
        found = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (LEDSEL !== 4'hF) begin
                found = 1;
                break;
            end
        end
        chk("lit_before_reset", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_ledsel", 32'(LEDSEL), 32'hF);
        chk("async_reset_ledout", 32'(LEDOUT), 32'hFF);
        chk("async_reset_fd", 32'(frame_done), 32'h0);
        tick(2);
        rst = 1'b1;
        rand_phase(300);

        en = 1'b1; blank_mask = '0; blink_mask = '0;
        tick(40);
        tick(2);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
